// File: rtl/spi_cmd_master_if.sv
// Command and SPI pins of spi_cmd_master.
// master modport: the SPI master itself (drives cmd_ready, cs, sclk, mosi, rd_*, busy).
// slave modport : the host/board side (drives the command fields and miso).
interface spi_cmd_master_if #(
    parameter int unsigned Nbit = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_rw;
    logic [6:0]      cmd_adr;
    logic [Nbit-1:0] cmd_data;
    logic            cs;
    logic            sclk;
    logic            mosi;
    logic            miso;
    logic [Nbit-1:0] rd_data;
    logic            rd_valid;
    logic            busy;

    modport master (
        input  cmd_valid, cmd_rw, cmd_adr, cmd_data, miso,
        output cmd_ready, cs, sclk, mosi, rd_data, rd_valid, busy
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_adr, cmd_data, miso,
        input  cmd_ready, cs, sclk, mosi, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI command master (mode 0). Serialises {rw, adr[6:0], data[Nbit-1:0]} MSB
// first as one cs-low frame; optionally captures miso on read frames.
// Ports: clk, rst (sync, active-high), bus (spi_cmd_master_if.master):
//   cmd_valid/cmd_ready handshake with cmd_rw/cmd_adr/cmd_data,
//   cs/sclk/mosi/miso SPI pins, rd_data/rd_valid readback, busy.
// Optional feature macro: SPI_MASTER_READBACK_EN (miso capture, rd_data,
// rd_valid). Without it rd_data/rd_valid are tied to 0 and miso is unused.
// Frame: SETUP (CLK_DIV) + (8+Nbit) sclk periods, the last low half being
// HOLD (CLK_DIV), so cs is low CLK_DIV*(2*(8+Nbit)+1) cycles; GAP of CS_GAP
// cycles follows before cmd_ready returns.
module spi_cmd_master #(
    parameter int unsigned Nbit    = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_cmd_master_if.master      bus
);
    localparam int unsigned FW      = 8 + Nbit;
    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned BIT_W   = $clog2(FW);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FW - 1);
    localparam logic [BIT_W-1:0] BIT_DATA0 = BIT_W'(8);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state;
    logic [FW-1:0]    shreg;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_cnt;

`ifdef SPI_MASTER_READBACK_EN
    logic            is_read;
    logic [Nbit-1:0] rd_shift;
`else
    logic unused_miso;
    assign unused_miso  = bus.miso;
    assign bus.rd_data  = '0;
    assign bus.rd_valid = 1'b0;
`endif

    // Frame sequencer; every output is a flop updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            bit_cnt       <= '0;
            bus.cs        <= 1'b1;
            bus.sclk      <= 1'b0;
            bus.mosi      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
`ifdef SPI_MASTER_READBACK_EN
            is_read      <= 1'b0;
            rd_shift     <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
`endif
        end else begin
`ifdef SPI_MASTER_READBACK_EN
            bus.rd_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        shreg         <= {bus.cmd_rw, bus.cmd_adr, bus.cmd_data};
                        bus.mosi      <= bus.cmd_rw;
                        bus.cs        <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        cnt           <= '0;
                        bit_cnt       <= '0;
                        state         <= SETUP;
`ifdef SPI_MASTER_READBACK_EN
                        is_read       <= ~bus.cmd_rw;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        bus.sclk <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (bus.sclk) begin
                            // Falling edge: advance mosi, or leave on the last bit.
                            bus.sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + BIT_W'(1);
                                shreg    <= {shreg[FW-2:0], 1'b0};
                                bus.mosi <= shreg[FW-2];
                            end
                        end else begin
                            bus.sclk <= 1'b1;
`ifdef SPI_MASTER_READBACK_EN
                            // Sample miso as sclk rises, data bits only.
                            if (is_read && (bit_cnt >= BIT_DATA0))
                                rd_shift <= Nbit'({rd_shift, bus.miso});
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        bus.cs   <= 1'b1;
                        bus.mosi <= 1'b0;
                        state    <= GAP;
`ifdef SPI_MASTER_READBACK_EN
                        if (is_read) begin
                            bus.rd_data  <= rd_shift;
                            bus.rd_valid <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt           <= '0;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master: instance A (Nbit=8, CLK_DIV=4, CS_GAP=4)
// and instance B (Nbit=16, CLK_DIV=2, CS_GAP=4), each with a register-write
// slave model (param_adr=1) decoding the mosi stream, plus a miso responder on A.
module tb_spi_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_cmd_master_if #(.Nbit(8))  ia ();
    spi_cmd_master_if #(.Nbit(16)) ib ();

    spi_cmd_master #(.Nbit(8), .CLK_DIV(4), .CS_GAP(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    spi_cmd_master #(.Nbit(16), .CLK_DIV(2), .CS_GAP(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    // Slave/monitor model for A, sampled on the falling clk edge.
    logic        a_prev_cs = 1'b1;
    logic        a_prev_sclk = 1'b0;
    logic [15:0] a_sh = '0;
    logic [7:0]  a_out = '0;
    logic [7:0]  a_miso_byte = 8'h3C;
    logic [7:0]  a_wr_q[$];
    int a_rises = 0, a_cslow = 0, a_frame_len = 0, a_rdv_cnt = 0;
    int a_rise_cyc = 0, a_gap = 0;

    always @(negedge clk) begin
        if (a_prev_cs && !ia.cs) begin
            a_gap   = cyc - a_rise_cyc;
            a_rises = 0;
            a_sh    = '0;
            a_cslow = 0;
        end
        if (!ia.cs) a_cslow++;
        if (!ia.cs && ia.sclk && !a_prev_sclk) begin
            a_sh = {a_sh[14:0], ia.mosi};
            a_rises++;
        end
        if (!a_prev_cs && ia.cs) begin
            a_rise_cyc  = cyc;
            a_frame_len = a_cslow;
            if (a_rises == 16 && a_sh[15] && a_sh[14:8] == 7'd1) begin
                a_out = a_sh[7:0];
                a_wr_q.push_back(a_sh[7:0]);
            end
        end
        if (ia.rd_valid) a_rdv_cnt++;
        if (!ia.cs && a_rises >= 8 && a_rises < 16) ia.miso = a_miso_byte[15 - a_rises];
        else ia.miso = 1'b0;
        a_prev_cs   = ia.cs;
        a_prev_sclk = ia.sclk;
    end

    // Slave/monitor model for B, with sclk phase-length tracking.
    logic        b_prev_cs = 1'b1;
    logic        b_prev_sclk = 1'b0;
    logic [23:0] b_sh = '0;
    logic [15:0] b_out = '0;
    int b_rises = 0, b_cslow = 0, b_frame_len = 0, b_run = 0, b_bad = 0, b_wr_cnt = 0;

    always @(negedge clk) begin
        if (b_prev_cs && !ib.cs) begin
            b_rises = 0;
            b_sh    = '0;
            b_cslow = 0;
            b_run   = 0;
        end
        if (!ib.cs) begin
            b_cslow++;
            if (b_run != 0 && ib.sclk !== b_prev_sclk) begin
                if (b_run != 2) b_bad++;
                b_run = 1;
            end else begin
                b_run++;
            end
        end
        if (!ib.cs && ib.sclk && !b_prev_sclk) begin
            b_sh = {b_sh[22:0], ib.mosi};
            b_rises++;
        end
        if (!b_prev_cs && ib.cs) begin
            b_frame_len = b_cslow;
            if (b_rises == 24 && b_sh[23] && b_sh[22:16] == 7'd1) begin
                b_out = b_sh[15:0];
                b_wr_cnt++;
            end
        end
        ib.miso     = 1'b0;
        b_prev_cs   = ib.cs;
        b_prev_sclk = ib.sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle indices (1 = first cycle after the accept edge) of frame events on A.
    int k_cs, k_sclk, k_rise, k_rdv, k_ready;

    task automatic run_a(input logic rw, input logic [6:0] adr, input logic [7:0] data,
                         input int rst_at);
        @(negedge clk);
        chk("a_ready_before_cmd", 32'(ia.cmd_ready), 32'd1);
        ia.cmd_valid = 1'b1;
        ia.cmd_rw    = rw;
        ia.cmd_adr   = adr;
        ia.cmd_data  = data;
        @(posedge clk);
        k_cs = 0; k_sclk = 0; k_rise = 0; k_rdv = 0; k_ready = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) ia.cmd_valid = 1'b0;
            if (k_cs == 0 && ia.cs == 1'b0) k_cs = k;
            if (k_sclk == 0 && ia.sclk) k_sclk = k;
            if (k_rise == 0 && k > 1 && ia.cs) k_rise = k;
            if (k_rdv == 0 && ia.rd_valid) k_rdv = k;
            if (k == rst_at) rst = 1'b1;
            if (ia.cmd_ready) begin
                k_ready = k;
                break;
            end
        end
    endtask

    initial begin
        int busy_low, second_acc, kb, wr_before, rdv_before;
        ia.cmd_valid = 1'b0; ia.cmd_rw = 1'b0; ia.cmd_adr = '0; ia.cmd_data = '0;
        ib.cmd_valid = 1'b0; ib.cmd_rw = 1'b0; ib.cmd_adr = '0; ib.cmd_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_cs",       32'(ia.cs), 32'd1);
        chk("rst_a_sclk",     32'(ia.sclk), 32'd0);
        chk("rst_a_mosi",     32'(ia.mosi), 32'd0);
        chk("rst_a_ready",    32'(ia.cmd_ready), 32'd1);
        chk("rst_a_busy",     32'(ia.busy), 32'd0);
        chk("rst_a_rd_valid", 32'(ia.rd_valid), 32'd0);
        chk("rst_a_rd_data",  32'(ia.rd_data), 32'd0);
        chk("rst_b_cs",       32'(ib.cs), 32'd1);
        chk("rst_b_ready",    32'(ib.cmd_ready), 32'd1);
        rst = 1'b0;

        // Write adr 1, data A5.
        run_a(1'b1, 7'h01, 8'hA5, 0);
        chk("wr_cs_fall_k",   32'(k_cs), 32'd1);
        chk("wr_first_rise_k", 32'(k_sclk), 32'd5);
        chk("wr_cs_rise_k",   32'(k_rise), 32'd133);
        chk("wr_ready_k",     32'(k_ready), 32'd137);
        chk("wr_mosi_stream", 32'(a_sh), 32'h81A5);
        chk("wr_rises",       32'(a_rises), 32'd16);
        chk("wr_cs_low_len",  32'(a_frame_len), 32'd132);
        chk("wr_slave_out",   32'(a_out), 32'hA5);
        chk("wr_slave_wr_cnt", 32'(a_wr_q.size()), 32'd1);
        chk("wr_no_rd_valid", 32'(a_rdv_cnt), 32'd0);

        // Read adr 5; responder returns 3C on the data byte.
        run_a(1'b0, 7'h05, 8'hFF, 0);
        chk("rd_addr_byte",   32'(a_sh[15:8]), 32'h05);
        chk("rd_cs_low_len",  32'(a_frame_len), 32'd132);
        chk("rd_ready_k",     32'(k_ready), 32'd137);
        chk("rd_slave_unchanged", 32'(a_out), 32'hA5);
`ifdef SPI_MASTER_READBACK_EN
        chk("rd_data",        32'(ia.rd_data), 32'h3C);
        chk("rd_valid_k",     32'(k_rdv), 32'd133);
        chk("rd_valid_pulses", 32'(a_rdv_cnt), 32'd1);
`else
        chk("rd_data_tied",   32'(ia.rd_data), 32'd0);
        chk("rd_valid_never", 32'(a_rdv_cnt), 32'd0);
`endif

        // Back-to-back writes with cmd_valid held high.
        @(negedge clk);
        ia.cmd_valid = 1'b1; ia.cmd_rw = 1'b1; ia.cmd_adr = 7'h01; ia.cmd_data = 8'h11;
        @(posedge clk);
        busy_low = 0; second_acc = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) ia.cmd_data = 8'h22;
            if (!ia.busy) busy_low++;
            if (ia.cmd_ready) begin
                second_acc = k;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        ia.cmd_valid = 1'b0;
        kb = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (ia.cmd_ready) begin
                kb = k;
                break;
            end
        end
        chk("b2b_second_accept_k", 32'(second_acc), 32'd137);
        chk("b2b_busy_low_cycles", 32'(busy_low), 32'd1);
        chk("b2b_cs_gap",          32'(a_gap), 32'd5);
        chk("b2b_second_done",     32'(kb != 0), 32'd1);
        chk("b2b_wr_count",        32'(a_wr_q.size()), 32'd3);
        chk("b2b_first_data",      32'(a_wr_q[1]), 32'h11);
        chk("b2b_second_data",     32'(a_wr_q[2]), 32'h22);

        // Reset in the middle of a read frame.
        wr_before  = a_wr_q.size();
        rdv_before = a_rdv_cnt;
        run_a(1'b0, 7'h01, 8'h00, 60);
        chk("rst_mid_ready_k", 32'(k_ready), 32'd61);
        chk("rst_mid_cs",      32'(ia.cs), 32'd1);
        chk("rst_mid_sclk",    32'(ia.sclk), 32'd0);
        chk("rst_mid_busy",    32'(ia.busy), 32'd0);
        chk("rst_mid_rd_data", 32'(ia.rd_data), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_rd_valid", 32'(a_rdv_cnt), 32'(rdv_before));
        chk("rst_mid_no_write",    32'(a_wr_q.size()), 32'(wr_before));
        chk("rst_mid_slave_out",   32'(a_out), 32'h22);

        // Parameter sweep instance: Nbit=16, CLK_DIV=2.
        @(negedge clk);
        ib.cmd_valid = 1'b1; ib.cmd_rw = 1'b1; ib.cmd_adr = 7'h01; ib.cmd_data = 16'hBEEF;
        @(posedge clk);
        kb = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) ib.cmd_valid = 1'b0;
            if (ib.cmd_ready) begin
                kb = k;
                break;
            end
        end
        chk("sweep_ready_k",    32'(kb), 32'd103);
        chk("sweep_rises",      32'(b_rises), 32'd24);
        chk("sweep_mosi",       32'(b_sh), 32'h0081BEEF);
        chk("sweep_cs_low_len", 32'(b_frame_len), 32'd98);
        chk("sweep_phase_errs", 32'(b_bad), 32'd0);
        chk("sweep_slave_out",  32'(b_out), 32'hBEEF);
        chk("sweep_wr_cnt",     32'(b_wr_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
